// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game score keeper.
// Holds the game-state encoding, keycodes, saturation limits and bus widths.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } game_state_e;

  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_RESET = 8'h01;

  localparam int unsigned SCORE_MAX = 9999;
  localparam int unsigned COMBO_MAX = 255;

  localparam int unsigned SCORE_W   = 14;
  localparam int unsigned BCD_W     = 16;
  localparam int unsigned COMBO_W   = 8;
  localparam int unsigned FRAME_W   = 12;
  localparam int unsigned KEY_W     = 8;
  localparam int unsigned STATE_W   = 2;
  localparam int unsigned SUM_W     = 24;

endpackage

// File: rtl/score_keeper_if.sv
// Game-side bus of the score keeper: keyboard and dropper lanes in,
// score, combo and game status out.
interface score_keeper_if #(
  parameter int unsigned LANES = 16
);

  logic [7:0]       keycode;
  logic [LANES-1:0] hit_vec;
  logic [LANES-1:0] miss_vec;
  logic [13:0]      score;
  logic [15:0]      score_bcd;
  logic [7:0]       combo;
  logic [7:0]       max_combo;
  logic [1:0]       game_state;
  logic             game_over;

  modport master (
    output keycode, hit_vec, miss_vec,
    input  score, score_bcd, combo, max_combo, game_state, game_over
  );

  modport slave (
    input  keycode, hit_vec, miss_vec,
    output score, score_bcd, combo, max_combo, game_state, game_over
  );

endinterface

// File: rtl/score_keeper_bcd.sv
// Combinational binary-to-BCD converter (double-dabble) for the score display.
// Inputs above 9999 are never presented; the fifth digit is therefore dropped.
module score_bcd
  import rhythm_pkg::*;
(
  input  logic [SCORE_W-1:0] i_bin,
  output logic [BCD_W-1:0]   o_bcd
);

  localparam int unsigned DD_W   = SCORE_W + BCD_W;
  localparam int unsigned DIGITS = BCD_W / 4;

  logic [DD_W-1:0] w_dd;

  // Add-3-then-shift on every digit that would overflow past 9 after doubling.
  always_comb begin
    w_dd = '0;
    w_dd[SCORE_W-1:0] = i_bin;
    for (int unsigned i = 0; i < SCORE_W; i++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (w_dd[SCORE_W + 4*d +: 4] >= 4'd5) begin
          w_dd[SCORE_W + 4*d +: 4] = w_dd[SCORE_W + 4*d +: 4] + 4'd3;
        end
      end
      w_dd = w_dd << 1;
    end
    o_bcd = w_dd[SCORE_W +: BCD_W];
  end

endmodule

// File: rtl/score_keeper.sv
// Rhythm-game score keeper: game FSM, per-lane rise detection, saturating
// score/combo/max-combo registers and BCD score output.
module score_keeper
  import rhythm_pkg::*;
#(
  parameter int unsigned LANES       = 16,
  parameter int unsigned SONG_FRAMES = 3000,
  parameter int unsigned HIT_POINTS  = 10
) (
  input  logic           frame_clk,
  input  logic           Reset,
  score_keeper_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(SONG_FRAMES - 1);

  game_state_e r_state;
  game_state_e w_state_next;
  logic        w_start;
  logic        w_play;

  logic [FRAME_W-1:0] r_frame_cnt;
  logic [LANES-1:0]   r_prev_hit;
  logic [LANES-1:0]   r_prev_miss;
  logic [LANES-1:0]   w_hit_rise;
  logic [LANES-1:0]   w_miss_rise;
  logic               w_any_miss;
  logic [CNT_W-1:0]   w_new_hits;

  logic [SUM_W-1:0]   w_score_sum;
  logic [SUM_W-1:0]   w_combo_sum;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_next;
  logic [COMBO_W-1:0] r_combo;
  logic [COMBO_W-1:0] w_combo_next;
  logic [COMBO_W-1:0] r_max_combo;
  logic [COMBO_W-1:0] w_max_next;
  logic               r_game_over;
  logic [BCD_W-1:0]   w_bcd;

  // Game state register.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; w_start flags the IDLE->PLAY edge that clears the game.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_play       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.keycode == KEY_START) begin
          w_state_next = ST_PLAY;
          w_start      = 1'b1;
        end
      end
      ST_PLAY: begin
        w_play = 1'b1;
        if (r_frame_cnt == LAST_FRAME) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.keycode == KEY_RESET) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Rising edges per lane; a lane that hits and misses together counts as a hit.
  always_comb begin
    w_hit_rise  = bus.hit_vec & ~r_prev_hit;
    w_miss_rise = bus.miss_vec & ~r_prev_miss & ~w_hit_rise;
    w_any_miss  = |w_miss_rise;
    w_new_hits  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_new_hits = w_new_hits + CNT_W'(w_hit_rise[i]);
    end
  end

  // Saturating score/combo arithmetic; a miss restarts combo before adding hits.
  always_comb begin
    w_score_sum = SUM_W'(r_score) + SUM_W'(HIT_POINTS) * SUM_W'(w_new_hits);
    w_combo_sum = (w_any_miss ? '0 : SUM_W'(r_combo)) + SUM_W'(w_new_hits);

    w_score_next = (w_score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                     : w_score_sum[SCORE_W-1:0];
    w_combo_next = (w_combo_sum > SUM_W'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX)
                                                     : w_combo_sum[COMBO_W-1:0];
    w_max_next   = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;
  end

  // Lane history is tracked in every state so held lanes never look new in PLAY.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_prev_hit  <= '0;
      r_prev_miss <= '0;
    end else begin
      r_prev_hit  <= bus.hit_vec;
      r_prev_miss <= bus.miss_vec;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_frame_cnt <= '0;
    end else if (w_start) begin
      r_frame_cnt <= '0;
    end else if (w_play) begin
      r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
    end
  end

  // Scoring registers: cleared on game start, updated only while playing.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
    end else if (w_start) begin
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
    end else if (w_play) begin
      r_score     <= w_score_next;
      r_combo     <= w_combo_next;
      r_max_combo <= w_max_next;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_game_over <= 1'b0;
    end else begin
      r_game_over <= (w_state_next == ST_DONE);
    end
  end

  score_bcd u_bcd (
    .i_bin (r_score),
    .o_bcd (w_bcd)
  );

  assign bus.score      = r_score;
  assign bus.score_bcd  = w_bcd;
  assign bus.combo      = r_combo;
  assign bus.max_combo  = r_max_combo;
  assign bus.game_state = STATE_W'(r_state);
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized play
// checked against a rule-level game model.
module tb_score_keeper;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_fail;

  // Reference model state, index 0 = long-song DUT, index 1 = 8-frame DUT.
  int          m_state [2];
  int          m_frame [2];
  int          m_score [2];
  int          m_combo [2];
  int          m_max   [2];
  logic [15:0] m_ph    [2];
  logic [15:0] m_pm    [2];
  int          sf      [2];
  int          hp      [2];

  score_keeper_if #(.LANES(16)) ifa ();
  score_keeper_if #(.LANES(16)) ifb ();

  score_keeper #(.LANES(16), .SONG_FRAMES(3000), .HIT_POINTS(10)) dut_a (
    .frame_clk (clk),
    .Reset     (rst_a),
    .bus       (ifa)
  );

  score_keeper #(.LANES(16), .SONG_FRAMES(8), .HIT_POINTS(10)) dut_b (
    .frame_clk (clk),
    .Reset     (rst_b),
    .bus       (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_step(input int u, input logic r, input logic [7:0] kc,
                            input logic [15:0] h, input logic [15:0] m);
    logic [15:0] hr;
    logic [15:0] mr;
    int nh;
    if (r) begin
      m_state[u] = 0; m_frame[u] = 0; m_score[u] = 0;
      m_combo[u] = 0; m_max[u] = 0; m_ph[u] = '0; m_pm[u] = '0;
    end else begin
      hr = h & ~m_ph[u];
      mr = m & ~m_pm[u] & ~hr;
      nh = $countones(hr);
      if (m_state[u] == 1) begin
        m_score[u] = m_score[u] + hp[u] * nh;
        if (m_score[u] > 9999) m_score[u] = 9999;
        m_combo[u] = (mr != 0) ? nh : m_combo[u] + nh;
        if (m_combo[u] > 255) m_combo[u] = 255;
        if (m_combo[u] > m_max[u]) m_max[u] = m_combo[u];
      end
      case (m_state[u])
        0: if (kc == 8'h2c) begin
             m_state[u] = 1; m_frame[u] = 0; m_score[u] = 0;
             m_combo[u] = 0; m_max[u] = 0;
           end
        1: if (m_frame[u] == sf[u] - 1) m_state[u] = 2;
           else m_frame[u] = m_frame[u] + 1;
        default: if (kc == 8'h01) m_state[u] = 0;
      endcase
      m_ph[u] = h;
      m_pm[u] = m;
    end
  endtask

  // Drive one frame of inputs, advance the model, then sample after the edge.
  task automatic cyc(input int u, input logic r, input logic [7:0] kc,
                     input logic [15:0] h, input logic [15:0] m);
    if (u == 0) begin
      rst_a = r; ifa.keycode = kc; ifa.hit_vec = h; ifa.miss_vec = m;
    end else begin
      rst_b = r; ifb.keycode = kc; ifb.hit_vec = h; ifb.miss_vec = m;
    end
    model_step(u, r, kc, h, m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1, 8'(i == 0 ? 8'h2c : $urandom), 16'($urandom), 16'($urandom));
      cyc(1, 1'b1, 8'h2c, 16'($urandom), 16'($urandom));
      n_checks++;
      if (ifa.score !== 14'd0 || ifa.score_bcd !== 16'h0000 || ifa.combo !== 8'd0 ||
          ifa.max_combo !== 8'd0 || ifa.game_state !== 2'b00 || ifa.game_over !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_a: score=%0d bcd=%h combo=%0d max=%0d state=%b over=%b, need all zero",
                 ifa.score, ifa.score_bcd, ifa.combo, ifa.max_combo, ifa.game_state, ifa.game_over);
      end
      n_checks++;
      if (ifb.score !== 14'd0 || ifb.combo !== 8'd0 || ifb.game_state !== 2'b00 ||
          ifb.game_over !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_b: score=%0d combo=%0d state=%b over=%b, need all zero",
                 ifb.score, ifb.combo, ifb.game_state, ifb.game_over);
      end
    end
  endtask

  task automatic test_first_hit();
    cyc(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(0, 1'b0, 8'h2c, 16'h0000, 16'h0000);
    n_checks++;
    if (ifa.game_state !== 2'b01) begin
      n_fail++;
      $display("FAIL start_play: state=%b need 01", ifa.game_state);
    end
    cyc(0, 1'b0, 8'h00, 16'h0008, 16'h0000);
    n_checks++;
    if (ifa.score !== 14'd10 || ifa.combo !== 8'd1 || ifa.max_combo !== 8'd1 ||
        ifa.score_bcd !== 16'h0010) begin
      n_fail++;
      $display("FAIL first_hit: score=%0d combo=%0d max=%0d bcd=%h need 10/1/1/0010",
               ifa.score, ifa.combo, ifa.max_combo, ifa.score_bcd);
    end
  endtask

  task automatic test_multi_hit();
    cyc(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(0, 1'b0, 8'h00, 16'h001F, 16'h0000);
    n_checks++;
    if (ifa.score !== 14'd60 || ifa.combo !== 8'd6 || ifa.max_combo !== 8'd6) begin
      n_fail++;
      $display("FAIL multi_hit: score=%0d combo=%0d max=%0d need 60/6/6",
               ifa.score, ifa.combo, ifa.max_combo);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'b0, 8'h00, 16'h001F, 16'h0000);
      n_checks++;
      if (ifa.score !== 14'd60 || ifa.combo !== 8'd6) begin
        n_fail++;
        $display("FAIL held_level %0d: score=%0d combo=%0d need 60/6", i, ifa.score, ifa.combo);
      end
    end
  endtask

  task automatic test_miss_combo();
    cyc(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(0, 1'b0, 8'h00, 16'h0001, 16'h0000);
    n_checks++;
    if (ifa.combo !== 8'd7 || ifa.max_combo !== 8'd7 || ifa.score !== 14'd70) begin
      n_fail++;
      $display("FAIL combo7: combo=%0d max=%0d score=%0d need 7/7/70",
               ifa.combo, ifa.max_combo, ifa.score);
    end
    cyc(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(0, 1'b0, 8'h00, 16'h0020, 16'h0004);
    n_checks++;
    if (ifa.combo !== 8'd1 || ifa.max_combo !== 8'd7 || ifa.score !== 14'd80) begin
      n_fail++;
      $display("FAIL miss_then_hit: combo=%0d max=%0d score=%0d need 1/7/80",
               ifa.combo, ifa.max_combo, ifa.score);
    end
    cyc(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(0, 1'b0, 8'h00, 16'h003F, 16'h0000);
    cyc(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(0, 1'b0, 8'h00, 16'h0040, 16'h0040);
    n_checks++;
    if (ifa.combo !== 8'd8 || ifa.max_combo !== 8'd8 || ifa.score !== 14'd150) begin
      n_fail++;
      $display("FAIL same_lane_hit_miss: combo=%0d max=%0d score=%0d need 8/8/150",
               ifa.combo, ifa.max_combo, ifa.score);
    end
  endtask

  task automatic test_random();
    logic [15:0] h;
    logic [15:0] m;
    for (int i = 0; i < 300; i++) begin
      h = 16'($urandom) & 16'($urandom);
      m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      cyc(0, 1'b0, 8'($urandom), h, m);
      n_checks++;
      if (ifa.score !== 14'(m_score[0]) || ifa.combo !== 8'(m_combo[0]) ||
          ifa.max_combo !== 8'(m_max[0]) || ifa.game_state !== 2'(m_state[0]) ||
          ifa.score_bcd !== to_bcd(m_score[0]) || ifa.game_over !== 1'(m_state[0] == 2)) begin
        n_fail++;
        $display("FAIL random %0d: score=%0d/%0d combo=%0d/%0d max=%0d/%0d state=%0d/%0d bcd=%h",
                 i, ifa.score, m_score[0], ifa.combo, m_combo[0], ifa.max_combo, m_max[0],
                 ifa.game_state, m_state[0], ifa.score_bcd);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 200; i++) begin
      cyc(0, 1'b0, 8'h00, (i % 2 == 0) ? 16'h0000 : 16'hFFFF, 16'h0000);
      n_checks++;
      if (ifa.score !== 14'(m_score[0]) || ifa.combo !== 8'(m_combo[0]) ||
          ifa.max_combo !== 8'(m_max[0]) || ifa.score_bcd !== to_bcd(m_score[0])) begin
        n_fail++;
        $display("FAIL saturate %0d: score=%0d/%0d combo=%0d/%0d max=%0d/%0d bcd=%h",
                 i, ifa.score, m_score[0], ifa.combo, m_combo[0], ifa.max_combo, m_max[0],
                 ifa.score_bcd);
      end
    end
    n_checks++;
    if (ifa.score !== 14'd9999 || ifa.score_bcd !== 16'h9999 || ifa.combo !== 8'd255) begin
      n_fail++;
      $display("FAIL score_cap: score=%0d bcd=%h combo=%0d need 9999/9999/255",
               ifa.score, ifa.score_bcd, ifa.combo);
    end
    cyc(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(0, 1'b0, 8'h00, 16'h0001, 16'h0000);
    n_checks++;
    if (ifa.score !== 14'd9999 || ifa.score_bcd !== 16'h9999) begin
      n_fail++;
      $display("FAIL score_hold_cap: score=%0d bcd=%h need 9999/9999", ifa.score, ifa.score_bcd);
    end
  endtask

  task automatic test_reset_mid_play();
    cyc(0, 1'b0, 8'h00, 16'hFFFF, 16'h0000);
    cyc(0, 1'b1, 8'h00, 16'hFFFF, 16'hFFFF);
    cyc(0, 1'b1, 8'h00, 16'hFFFF, 16'hFFFF);
    n_checks++;
    if (ifa.score !== 14'd0 || ifa.score_bcd !== 16'h0000 || ifa.combo !== 8'd0 ||
        ifa.max_combo !== 8'd0 || ifa.game_state !== 2'b00 || ifa.game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_play: score=%0d combo=%0d max=%0d state=%b need zeros/IDLE",
               ifa.score, ifa.combo, ifa.max_combo, ifa.game_state);
    end
    cyc(0, 1'b0, 8'h2c, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b0, 8'h00, 16'hFFFF, 16'hFFFF);
      n_checks++;
      if (ifa.game_state !== 2'b01 || ifa.score !== 14'd0 || ifa.combo !== 8'd0) begin
        n_fail++;
        $display("FAIL held_after_reset %0d: state=%b score=%0d combo=%0d need 01/0/0",
                 i, ifa.game_state, ifa.score, ifa.combo);
      end
    end
    cyc(0, 1'b0, 8'h00, 16'hFF7F, 16'hFFFF);
    cyc(0, 1'b0, 8'h00, 16'hFFFF, 16'hFFFF);
    n_checks++;
    if (ifa.score !== 14'd10 || ifa.combo !== 8'd1) begin
      n_fail++;
      $display("FAIL re_rise: score=%0d combo=%0d need 10/1", ifa.score, ifa.combo);
    end
  endtask

  task automatic test_song_end();
    cyc(1, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(1, 1'b0, 8'h2c, 16'h0000, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1'b0, 8'h00, 16'h0000, 16'h0000);
      n_checks++;
      if (ifb.game_state !== 2'b01 || ifb.game_over !== 1'b0) begin
        n_fail++;
        $display("FAIL early_done %0d: state=%b over=%b need 01/0", i, ifb.game_state, ifb.game_over);
      end
    end
    cyc(1, 1'b0, 8'h00, 16'h0003, 16'h0000);
    n_checks++;
    if (ifb.game_state !== 2'b10 || ifb.game_over !== 1'b1 || ifb.score !== 14'd20 ||
        ifb.combo !== 8'd2) begin
      n_fail++;
      $display("FAIL song_end: state=%b over=%b score=%0d combo=%0d need 10/1/20/2",
               ifb.game_state, ifb.game_over, ifb.score, ifb.combo);
    end
    cyc(1, 1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(1, 1'b0, 8'h2c, 16'h00F0, 16'h0F00);
    n_checks++;
    if (ifb.game_state !== 2'b10 || ifb.score !== 14'd20 || ifb.combo !== 8'd2 ||
        ifb.max_combo !== 8'd2) begin
      n_fail++;
      $display("FAIL done_hold: state=%b score=%0d combo=%0d max=%0d need 10/20/2/2",
               ifb.game_state, ifb.score, ifb.combo, ifb.max_combo);
    end
    cyc(1, 1'b0, 8'h01, 16'h0000, 16'h0000);
    n_checks++;
    if (ifb.game_state !== 2'b00 || ifb.game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_idle: state=%b over=%b need 00/0", ifb.game_state, ifb.game_over);
    end
    cyc(1, 1'b0, 8'h2c, 16'h0000, 16'h0000);
    n_checks++;
    if (ifb.game_state !== 2'b01 || ifb.score !== 14'd0 || ifb.combo !== 8'd0 ||
        ifb.max_combo !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_clear: state=%b score=%0d combo=%0d max=%0d need 01/0/0/0",
               ifb.game_state, ifb.score, ifb.combo, ifb.max_combo);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sf[0] = 3000; sf[1] = 8;
    hp[0] = 10;   hp[1] = 10;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.keycode = 8'h00; ifa.hit_vec = '0; ifa.miss_vec = '0;
    ifb.keycode = 8'h00; ifb.hit_vec = '0; ifb.miss_vec = '0;
    #2;
    test_reset();
    test_first_hit();
    test_multi_hit();
    test_miss_combo();
    test_random();
    test_saturation();
    test_reset_mid_play();
    test_song_end();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
